// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter: one-hot select plus binary index for the downstream mux.
// Optional lock-in holds the winner while the downstream port stalls.
module rr_onehot_arbiter #(
  parameter int unsigned NumIn    = 4,
  parameter bit          LockIn   = 1'b1,
  parameter int unsigned IdxWidth = (NumIn == 1) ? 1 : $clog2(NumIn)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic [NumIn-1:0]    req_i,
  output logic [NumIn-1:0]    gnt_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [IdxWidth-1:0] idx_o
);

  logic [IdxWidth-1:0] rr_q;
  logic [IdxWidth-1:0] lidx_q;
  logic                lock_q;
  logic [NumIn-1:0]    sel;
  logic                found;
  logic                hs;
  logic [IdxWidth-1:0] rr_nxt;

  // Two passes give the wrapped search: indices >= rr_q first, then the rest.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    if (lock_q) begin
      sel[lidx_q] = 1'b1;
    end else begin
      for (int i = 0; i < int'(NumIn); i++) begin
        if (!found && req_i[i] && (IdxWidth'(i) >= rr_q)) begin
          sel[i] = 1'b1;
          found  = 1'b1;
        end
      end
      for (int i = 0; i < int'(NumIn); i++) begin
        if (!found && req_i[i]) begin
          sel[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < int'(NumIn); i++) begin
      if (sel[i]) idx_o = idx_o | IdxWidth'(i);
    end
  end

  assign valid_o = lock_q ? req_i[lidx_q] : |req_i;
  assign hs      = valid_o && ready_i;
  assign gnt_o   = sel & {NumIn{hs}};
  assign rr_nxt  = (idx_o == IdxWidth'(NumIn - 1)) ? '0 : idx_o + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q   <= '0;
      lock_q <= 1'b0;
      lidx_q <= '0;
    end else if (flush_i) begin
      rr_q   <= '0;
      lock_q <= 1'b0;
    end else begin
      if (hs) rr_q <= rr_nxt;
      if (LockIn) begin
        if (valid_o && !ready_i && !lock_q) begin
          lock_q <= 1'b1;
          lidx_q <= idx_o;
        end else if (hs && lock_q) begin
          lock_q <= 1'b0;
        end
      end
    end
  end

`ifndef SYNTHESIS
  a_gnt_onehot: assert property (
    @(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));

  a_idx_range: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    valid_o |-> (int'(idx_o) < int'(NumIn)));

  a_idx_stable: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (LockIn && valid_o && !ready_i && !flush_i)
    |=> (idx_o == $past(idx_o)));

  // A locked requester must hold its request until granted.
  a_lock_req: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    lock_q |-> req_i[lidx_q]);
`endif

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed bench for rr_onehot_arbiter: rotation, wrap, lock-in, flush,
// non-power-of-two width and asynchronous reset while locked.
module tb_rr_onehot_arbiter;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       flush;
  logic       ready;
  logic [3:0] req4;
  logic [3:0] gnt0, gnt1;
  logic       valid0, valid1;
  logic [1:0] idx0, idx1;

  logic       flush3;
  logic       ready3;
  logic [2:0] req3;
  logic [2:0] gnt3;
  logic       valid3;
  logic [1:0] idx3;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  rr_onehot_arbiter #(.NumIn(4), .LockIn(1'b1)) u_lock (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush),
    .req_i(req4), .gnt_o(gnt0), .valid_o(valid0),
    .ready_i(ready), .idx_o(idx0));

  rr_onehot_arbiter #(.NumIn(4), .LockIn(1'b0)) u_nolock (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush),
    .req_i(req4), .gnt_o(gnt1), .valid_o(valid1),
    .ready_i(ready), .idx_o(idx1));

  rr_onehot_arbiter #(.NumIn(3), .LockIn(1'b1)) u_n3 (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush3),
    .req_i(req3), .gnt_o(gnt3), .valid_o(valid3),
    .ready_i(ready3), .idx_o(idx3));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    flush  = 1'b0;
    ready  = 1'b0;
    req4   = '0;
    flush3 = 1'b0;
    ready3 = 1'b0;
    req3   = '0;

    #2;
    chk("rst_valid", 32'(valid0), 0);
    chk("rst_gnt", 32'(gnt0), 0);
    chk("rst_idx", 32'(idx0), 0);
    cyc();
    rst_ni = 1'b1;

    // full rotation
    req4  = 4'b1111;
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      chk($sformatf("rot_idx%0d", i), 32'(idx0), 32'(i % 4));
      chk($sformatf("rot_gnt%0d", i), 32'(gnt0), 32'(1 << (i % 4)));
      cyc();
    end

    // grant 1 -> rr=2, then wrap search picks 0
    req4 = 4'b0010;
    @(negedge clk_i);
    chk("g1_idx", 32'(idx0), 1);
    cyc();
    req4 = 4'b0011;
    @(negedge clk_i);
    chk("wrap_idx", 32'(idx0), 0);
    chk("wrap_gnt", 32'(gnt0), 32'b0001);
    cyc();

    // handshake in a flush cycle still grants, pointer returns to 0
    flush = 1'b1;
    req4  = 4'b0100;
    @(negedge clk_i);
    chk("fl_gnt", 32'(gnt0), 32'b0100);
    cyc();
    flush = 1'b0;
    req4  = 4'b1010;
    @(negedge clk_i);
    chk("fl_rr0_idx", 32'(idx0), 1);
    cyc();
    flush = 1'b1;
    req4  = '0;
    ready = 1'b0;
    cyc();
    flush = 1'b0;

    // lock-in under stall
    req4 = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk($sformatf("lk_idx%0d", i), 32'(idx0), 2);
      chk($sformatf("lk_gnt%0d", i), 32'(gnt0), 0);
      cyc();
    end
    req4 = 4'b0101;
    @(negedge clk_i);
    chk("lk_hold_idx", 32'(idx0), 2);
    chk("nolk_idx", 32'(idx1), 0);
    chk("lk_valid", 32'(valid0), 1);
    cyc();
    ready = 1'b1;
    @(negedge clk_i);
    chk("lk_gnt", 32'(gnt0), 32'b0100);
    chk("nolk_gnt", 32'(gnt1), 32'b0001);
    cyc();
    req4 = 4'b0001;
    @(negedge clk_i);
    chk("post_lk_idx", 32'(idx0), 0);
    chk("post_lk_gnt", 32'(gnt0), 32'b0001);
    cyc();

    // NumIn=3: wrap after idx 2, flush while locked on idx 1
    req4   = '0;
    ready  = 1'b0;
    req3   = 3'b100;
    ready3 = 1'b1;
    @(negedge clk_i);
    chk("n3_idx2", 32'(idx3), 2);
    chk("n3_gnt2", 32'(gnt3), 32'b100);
    cyc();
    req3 = 3'b111;
    @(negedge clk_i);
    chk("n3_wrap_idx", 32'(idx3), 0);
    cyc();
    req3   = 3'b010;
    ready3 = 1'b0;
    @(negedge clk_i);
    chk("n3_lk_idx", 32'(idx3), 1);
    cyc();
    req3   = 3'b011;
    flush3 = 1'b1;
    @(negedge clk_i);
    chk("n3_flcyc_idx", 32'(idx3), 1);
    chk("n3_flcyc_gnt", 32'(gnt3), 0);
    cyc();
    flush3 = 1'b0;
    ready3 = 1'b1;
    @(negedge clk_i);
    chk("n3_postfl_idx", 32'(idx3), 0);
    chk("n3_postfl_gnt", 32'(gnt3), 32'b001);
    cyc();
    req3 = 3'b010;
    @(negedge clk_i);
    chk("n3_last_gnt", 32'(gnt3), 32'b010);
    cyc();
    req3   = '0;
    ready3 = 1'b0;

    // async reset while locked (u_lock rr=1 here)
    req4 = 4'b0100;
    @(negedge clk_i);
    chk("rl_idx", 32'(idx0), 2);
    cyc();
    req4 = 4'b0110;
    @(negedge clk_i);
    chk("rl_locked_idx", 32'(idx0), 2);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("rl_valid", 32'(valid0), 1);
    chk("rl_idx_after", 32'(idx0), 1);
    chk("rl_gnt", 32'(gnt0), 0);
    cyc();
    req4 = '0;
    cyc();
    rst_ni = 1'b1;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
